// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel enable divider, h/v counters and registered sync/qualifier outputs.
// Every decode is taken from the next-state counters, so syncs line up with the coordinates they accompany.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;
    logic             w_x_wrap;
    logic             w_y_wrap;
    logic             r_tick;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_start;
    logic             r_frame_start;

    always_comb begin
        w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        w_x_wrap   = r_tick && (r_x == H_LAST);
        w_y_wrap   = w_x_wrap && (r_y == V_LAST);
        w_x_next   = r_x;
        w_y_next   = r_y;
        // Coordinates only move on the edge that closes a pixel period.
        if (r_tick) begin
            if (w_x_wrap) begin
                w_x_next = 10'd0;
                w_y_next = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div         <= '0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_tick        <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_next;
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_tick        <= (w_div_next == DIV_LAST);
            r_hsync       <= (w_x_next >= HS_START && w_x_next < HS_END) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_y_next >= VS_START && w_y_next < VS_END) ? SYNC_POL : ~SYNC_POL;
            r_video_on    <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_y_wrap;
        end
    end

    assign pixel_tick  = r_tick;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
